// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the CNN line-buffer sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam int DEF_MAP_WIDTH  = 24;
  localparam int DEF_MAP_HEIGHT = 24;
  localparam int DEF_DATA_WIDTH = 16;

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/linebuf_ctrl_if.sv
// Control/stream bundle between the line-buffer sequencer and its neighbours.
// Latency: n/a (wires only).
// Backpressure: s_ready is driven by the sequencer, m_ready by downstream.
// Signals: start, m_ready, s_data/s_valid/s_ready, lb_clr, lb_din/lb_in_valid,
//          win_valid/win_row/win_col, busy, done.
interface linebuf_ctrl_if
  import cnn_pkg::*;
#(
  parameter int MAP_WIDTH  = DEF_MAP_WIDTH,
  parameter int MAP_HEIGHT = DEF_MAP_HEIGHT,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                          start;
  logic                          m_ready;
  logic [DATA_WIDTH-1:0]         s_data;
  logic                          s_valid;
  logic                          s_ready;
  logic                          lb_clr;
  logic [DATA_WIDTH-1:0]         lb_din;
  logic                          lb_in_valid;
  logic                          win_valid;
  logic [cnt_w(MAP_HEIGHT)-1:0]  win_row;
  logic [cnt_w(MAP_WIDTH)-1:0]   win_col;
  logic                          busy;
  logic                          done;

  modport master (
    output start, m_ready, s_data, s_valid,
    input  s_ready, lb_clr, lb_din, lb_in_valid, win_valid, win_row, win_col, busy, done
  );

  modport slave (
    input  start, m_ready, s_data, s_valid,
    output s_ready, lb_clr, lb_din, lb_in_valid, win_valid, win_row, win_col, busy, done
  );

endinterface

// File: rtl/valid_delay_pipe.sv
// Fixed-depth shift register for a {valid,row,col} tag, clocked every cycle.
// Latency: DEPTH cycles from d_i to q_o.
// Backpressure: none; the pipe never stalls.
// Ports: clk, rst (sync, active-high), d_i (tag in), q_o (tag out).
module valid_delay_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/linebuf_ctrl.sv
// Sequences one feature map per start into the line buffer and tags completed windows.
// Latency: lb_din 1 cycle after accept; win_* LB_LATENCY+1 cycles after accept.
// Backpressure: s_ready follows m_ready while streaming; tags already in flight still emerge.
// Ports: clk, rst (sync, active-high), bus (slave side of linebuf_ctrl_if).
module linebuf_ctrl
  import cnn_pkg::*;
#(
  parameter int MAP_WIDTH  = DEF_MAP_WIDTH,
  parameter int MAP_HEIGHT = DEF_MAP_HEIGHT,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KERNEL     = 2,
  parameter int STRIDE     = 2,
  parameter int LB_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  linebuf_ctrl_if.slave bus
);

  localparam int RW = cnt_w(MAP_HEIGHT);
  localparam int CW = cnt_w(MAP_WIDTH);
  localparam int PW = cnt_w(STRIDE);
  localparam int DW = cnt_w(LB_LATENCY + 1);
  localparam int TW = 1 + RW + CW;

  state_t                state_q, state_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [DW-1:0]         drn_q, drn_d;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  vld_q, clr_q, done_q;
  logic                  accept, last_col, last_row, drain_end;
  logic                  hit_r, hit_c;
  logic [RW-1:0]         idx_r;
  logic [CW-1:0]         idx_c;
  logic [TW-1:0]         tag_d, tag_q;

  assign bus.s_ready = (state_q == STREAM) && bus.m_ready;
  assign accept      = bus.s_ready && bus.s_valid;
  assign last_col    = (col_q == CW'(MAP_WIDTH - 1));
  assign last_row    = (row_q == RW'(MAP_HEIGHT - 1));
  // DRAIN lasts LB_LATENCY+1 cycles so done lands just after the last possible tag.
  assign drain_end   = (state_q == DRAIN) && (drn_q == DW'(LB_LATENCY));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    drn_d   = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = STREAM;
          row_d   = '0;
          col_d   = '0;
        end
      end
      STREAM: begin
        if (accept) begin
          if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + 1'b1;
            if (last_row) state_d = DRAIN;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        drn_d = drn_q + 1'b1;
        if (drain_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      drn_q   <= '0;
      din_q   <= '0;
      vld_q   <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drn_q   <= drn_d;
      vld_q   <= accept;
      clr_q   <= (state_q == IDLE) && bus.start;
      done_q  <= drain_end;
      if (accept) din_q <= bus.s_data;
    end
  end

  // Window hit/index for the pixel being accepted at (row_q, col_q).
  if ((STRIDE & (STRIDE - 1)) == 0) begin : g_pow2
    localparam int SH = $clog2(STRIDE);
    logic [RW-1:0] dr;
    logic [CW-1:0] dc;
    assign dr    = row_q - RW'(KERNEL - 1);
    assign dc    = col_q - CW'(KERNEL - 1);
    assign hit_r = (row_q >= RW'(KERNEL - 1)) && ((dr & RW'(STRIDE - 1)) == '0);
    assign hit_c = (col_q >= CW'(KERNEL - 1)) && ((dc & CW'(STRIDE - 1)) == '0);
    assign idx_r = dr >> SH;
    assign idx_c = dc >> SH;
  end else begin : g_cnt
    // Phase counters step once per row/col past KERNEL-1; phase 0 marks a window.
    logic [PW-1:0] rph_q, cph_q;
    logic [RW-1:0] wrow_q;
    logic [CW-1:0] wcol_q;
    assign hit_r = (row_q >= RW'(KERNEL - 1)) && (rph_q == '0);
    assign hit_c = (col_q >= CW'(KERNEL - 1)) && (cph_q == '0);
    assign idx_r = wrow_q;
    assign idx_c = wcol_q;
    always_ff @(posedge clk) begin
      if (rst || (state_q == IDLE)) begin
        rph_q  <= '0;
        cph_q  <= '0;
        wrow_q <= '0;
        wcol_q <= '0;
      end else if (accept) begin
        if (last_col) begin
          cph_q  <= '0;
          wcol_q <= '0;
          if (row_q >= RW'(KERNEL - 1)) begin
            if (rph_q == PW'(STRIDE - 1)) begin
              rph_q  <= '0;
              wrow_q <= wrow_q + 1'b1;
            end else begin
              rph_q <= rph_q + 1'b1;
            end
          end
        end else if (col_q >= CW'(KERNEL - 1)) begin
          if (cph_q == PW'(STRIDE - 1)) begin
            cph_q  <= '0;
            wcol_q <= wcol_q + 1'b1;
          end else begin
            cph_q <= cph_q + 1'b1;
          end
        end
      end
    end
  end

  // Indices are zeroed with the valid bit so win_row/win_col read 0 between tags.
  assign tag_d = (accept && hit_r && hit_c) ? {1'b1, idx_r, idx_c} : '0;

  valid_delay_pipe #(
    .DEPTH (LB_LATENCY + 1),
    .WIDTH (TW)
  ) u_tag_pipe (
    .clk (clk),
    .rst (rst),
    .d_i (tag_d),
    .q_o (tag_q)
  );

  assign {bus.win_valid, bus.win_row, bus.win_col} = tag_q;
  assign bus.lb_clr      = clr_q;
  assign bus.lb_din      = din_q;
  assign bus.lb_in_valid = vld_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;

endmodule

// File: tb/tb_linebuf_ctrl.sv
// Bench for linebuf_ctrl: four parameter sets share one cycle-level scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_linebuf_ctrl;
  import cnn_pkg::*;

  localparam int DWD  = 16;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, start_r, s_valid_r, m_ready_r;
  logic [DWD-1:0] s_data_r;
  int             sel;

  linebuf_ctrl_if #(.MAP_WIDTH(4), .MAP_HEIGHT(4), .DATA_WIDTH(DWD)) ifa ();
  linebuf_ctrl_if #(.MAP_WIDTH(5), .MAP_HEIGHT(5), .DATA_WIDTH(DWD)) ifb ();
  linebuf_ctrl_if #(.MAP_WIDTH(7), .MAP_HEIGHT(6), .DATA_WIDTH(DWD)) ifc ();
  linebuf_ctrl_if #(.MAP_WIDTH(5), .MAP_HEIGHT(4), .DATA_WIDTH(DWD)) ifd ();

  linebuf_ctrl #(.MAP_WIDTH(4), .MAP_HEIGHT(4), .DATA_WIDTH(DWD), .KERNEL(2), .STRIDE(2), .LB_LATENCY(1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  linebuf_ctrl #(.MAP_WIDTH(5), .MAP_HEIGHT(5), .DATA_WIDTH(DWD), .KERNEL(3), .STRIDE(1), .LB_LATENCY(1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  linebuf_ctrl #(.MAP_WIDTH(7), .MAP_HEIGHT(6), .DATA_WIDTH(DWD), .KERNEL(2), .STRIDE(3), .LB_LATENCY(2))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));
  linebuf_ctrl #(.MAP_WIDTH(5), .MAP_HEIGHT(4), .DATA_WIDTH(DWD), .KERNEL(2), .STRIDE(2), .LB_LATENCY(1))
    dut_d (.clk(clk), .rst(rst), .bus(ifd));

  assign ifa.start = start_r && (sel == 0);
  assign ifa.s_valid = s_valid_r;
  assign ifa.m_ready = m_ready_r;
  assign ifa.s_data = s_data_r;
  assign ifb.start = start_r && (sel == 1);
  assign ifb.s_valid = s_valid_r;
  assign ifb.m_ready = m_ready_r;
  assign ifb.s_data = s_data_r;
  assign ifc.start = start_r && (sel == 2);
  assign ifc.s_valid = s_valid_r;
  assign ifc.m_ready = m_ready_r;
  assign ifc.s_data = s_data_r;
  assign ifd.start = start_r && (sel == 3);
  assign ifd.s_valid = s_valid_r;
  assign ifd.m_ready = m_ready_r;
  assign ifd.s_data = s_data_r;

  typedef struct packed {
    logic           sr, clr, vld;
    logic [DWD-1:0] din;
    logic           wv;
    logic [7:0]     wr, wc;
    logic           busy, done;
  } obs_t;

  obs_t oa, ob, oc, od, obs;
  assign oa = {ifa.s_ready, ifa.lb_clr, ifa.lb_in_valid, ifa.lb_din, ifa.win_valid,
               8'(ifa.win_row), 8'(ifa.win_col), ifa.busy, ifa.done};
  assign ob = {ifb.s_ready, ifb.lb_clr, ifb.lb_in_valid, ifb.lb_din, ifb.win_valid,
               8'(ifb.win_row), 8'(ifb.win_col), ifb.busy, ifb.done};
  assign oc = {ifc.s_ready, ifc.lb_clr, ifc.lb_in_valid, ifc.lb_din, ifc.win_valid,
               8'(ifc.win_row), 8'(ifc.win_col), ifc.busy, ifc.done};
  assign od = {ifd.s_ready, ifd.lb_clr, ifd.lb_in_valid, ifd.lb_din, ifd.win_valid,
               8'(ifd.win_row), 8'(ifd.win_col), ifd.busy, ifd.done};

  always_comb begin
    obs = oa;
    case (sel)
      1: obs = ob;
      2: obs = oc;
      3: obs = od;
      default: obs = oa;
    endcase
  end

  // Reference model: expected outputs scheduled per absolute cycle.
  logic           e_clr [MAXC];
  logic           e_vld [MAXC];
  logic [DWD-1:0] e_din [MAXC];
  logic           e_wv  [MAXC];
  int             e_wr  [MAXC];
  int             e_wc  [MAXC];
  logic           e_done[MAXC];

  int W, H, K, S, LAT;
  int mode;            // 0 idle, 1 streaming, 2 waiting for done
  int n;               // pixels accepted in current frame
  int done_cyc, cyc;
  logic [DWD-1:0] din_hold;
  logic prev_rst;
  int checks, failures;
  int dut_wins, dut_dones, dut_done_cyc, start_cyc;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, o, e, cyc);
    end
  endtask

  task automatic clear_at(input int t);
    e_clr[t] = 1'b0; e_vld[t] = 1'b0; e_din[t] = '0;
    e_wv[t] = 1'b0; e_wr[t] = 0; e_wc[t] = 0; e_done[t] = 1'b0;
  endtask

  task automatic step(input logic st, sv, mr, rs, input logic [DWD-1:0] d);
    logic exp_sr, acc;
    int r, c;
    @(posedge clk); #1;
    cyc++;
    start_r = st; s_valid_r = sv; m_ready_r = mr; rst = rs; s_data_r = d;
    if (mode == 2 && cyc == done_cyc) mode = 0;
    if (prev_rst) din_hold = '0;
    else if (e_vld[cyc]) din_hold = e_din[cyc];
    exp_sr = (mode == 1) && mr;
    acc    = exp_sr && sv;
    @(negedge clk);
    chk("s_ready", 32'(obs.sr), 32'(exp_sr));
    chk("lb_clr", 32'(obs.clr), 32'(e_clr[cyc]));
    chk("lb_in_valid", 32'(obs.vld), 32'(e_vld[cyc]));
    chk("lb_din", 32'(obs.din), 32'(din_hold));
    chk("win_valid", 32'(obs.wv), 32'(e_wv[cyc]));
    chk("win_row", 32'(obs.wr), e_wr[cyc]);
    chk("win_col", 32'(obs.wc), e_wc[cyc]);
    chk("busy", 32'(obs.busy), 32'(mode != 0));
    chk("done", 32'(obs.done), 32'(e_done[cyc]));
    if (obs.wv === 1'b1) dut_wins++;
    if (obs.done === 1'b1) begin dut_dones++; dut_done_cyc = cyc; end
    if (rs) begin
      mode = 0;
      for (int k2 = 1; k2 <= LAT + 2; k2++) clear_at(cyc + k2);
    end else if (mode == 0 && st) begin
      mode = 1; n = 0; e_clr[cyc+1] = 1'b1;
    end else if (mode == 1 && acc) begin
      r = n / W; c = n % W;
      e_vld[cyc+1] = 1'b1; e_din[cyc+1] = d;
      if (r >= K-1 && c >= K-1 && (r-K+1) % S == 0 && (c-K+1) % S == 0) begin
        e_wv[cyc+1+LAT] = 1'b1;
        e_wr[cyc+1+LAT] = (r-K+1) / S;
        e_wc[cyc+1+LAT] = (c-K+1) / S;
      end
      n++;
      if (n == W*H) begin
        mode = 2; done_cyc = cyc + LAT + 2; e_done[done_cyc] = 1'b1;
      end
    end
    prev_rst = rs;
  endtask

  // vm: 0 always valid, 1 toggle, 2 random; mm: 0 always ready, 1 low 5 cycles
  // after pixel 7, 2 random; sm: 0 no extra start, 1 mid-frame and drain, 2 random;
  // ra: pixel count after which rst is pulsed (-1 none).
  task automatic frame(input int vm, mm, sm, ra);
    int k, low;
    logic sv, mr, st, rs, fired;
    logic [DWD-1:0] d;
    dut_wins = 0; dut_dones = 0; dut_done_cyc = -1;
    start_cyc = cyc + 1;
    low = 0; fired = 1'b0; k = 0;
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    while (mode != 0 && k < 400) begin
      sv = (vm == 0) ? 1'b1 : (vm == 1) ? (k % 2 == 0) : ($urandom_range(0, 99) < 70);
      if (mm == 1) begin
        mr = 1'b1;
        if (n >= 7 && low < 5) begin mr = 1'b0; low++; end
      end else begin
        mr = (mm == 0) ? 1'b1 : ($urandom_range(0, 99) < 80);
      end
      if (sm == 1) st = (mode == 1 && n == 5) || (mode == 2 && cyc + 1 != done_cyc);
      else st = (sm == 2) && ($urandom_range(0, 19) == 0);
      rs = 1'b0;
      if (ra >= 0 && !fired && mode == 1 && n == ra) begin rs = 1'b1; fired = 1'b1; end
      d = (vm == 2) ? DWD'($urandom) : DWD'(n + 1);
      step(st, sv, mr, rs, d);
      k++;
    end
    chk("frame_timeout", 32'(k < 400), 32'd1);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic use_cfg(input int s, w, h, kk, ss, l);
    sel = s; W = w; H = h; K = kk; S = ss; LAT = l;
    din_hold = '0;
    step(1'b0, 1'b0, 1'b1, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; mode = 0; n = 0; done_cyc = -1;
    din_hold = '0; prev_rst = 1'b1; sel = 0;
    W = 4; H = 4; K = 2; S = 2; LAT = 1;
    for (int i = 0; i < MAXC; i++) clear_at(i);
    rst = 1'b1; start_r = 1'b0; s_valid_r = 1'b0; m_ready_r = 1'b1; s_data_r = '0;
    repeat (2) @(posedge clk);

    // 4x4, K=2, S=2, latency 1
    use_cfg(0, 4, 4, 2, 2, 1);
    frame(0, 0, 0, -1);
    chk("A_wins", dut_wins, 4);
    chk("A_dones", dut_dones, 1);
    chk("A_done_lat", dut_done_cyc - start_cyc, 19);
    frame(1, 0, 0, -1);
    chk("A_toggle_wins", dut_wins, 4);
    chk("A_toggle_dones", dut_dones, 1);
    frame(0, 1, 0, -1);
    chk("A_mready_wins", dut_wins, 4);
    chk("A_mready_lat", dut_done_cyc - start_cyc, 24);
    frame(0, 0, 1, -1);
    chk("A_restart_dones", dut_dones, 1);
    chk("A_restart_wins", dut_wins, 4);
    frame(0, 0, 0, 9);
    chk("A_abort_dones", dut_dones, 0);
    chk("A_abort_wins", dut_wins, 2);
    frame(0, 0, 0, -1);
    chk("A_fresh_wins", dut_wins, 4);
    chk("A_fresh_lat", dut_done_cyc - start_cyc, 19);
    repeat (4) frame(2, 2, 2, -1);
    frame(2, 2, 0, $urandom_range(1, 14));

    // 5x5, K=3, S=1
    use_cfg(1, 5, 5, 3, 1, 1);
    frame(0, 0, 0, -1);
    chk("B_wins", dut_wins, 9);
    chk("B_done_lat", dut_done_cyc - start_cyc, 28);
    repeat (3) frame(2, 2, 2, -1);

    // 7x6, K=2, S=3, latency 2: trailing columns/rows never tagged
    use_cfg(2, 7, 6, 2, 3, 2);
    frame(0, 0, 0, -1);
    chk("C_wins", dut_wins, 4);
    chk("C_done_lat", dut_done_cyc - start_cyc, 46);
    repeat (2) frame(2, 2, 2, -1);

    // 5x4, K=2, S=2: odd width leaves last column untagged
    use_cfg(3, 5, 4, 2, 2, 1);
    frame(0, 0, 0, -1);
    chk("D_wins", dut_wins, 4);
    chk("D_done_lat", dut_done_cyc - start_cyc, 23);
    repeat (2) frame(2, 2, 2, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/linebuf_ctrl.md
Name: linebuf_ctrl

Overview:
- Sequencer for the 2-row line-buffer datapath of the CNN pooling/conv stage.
- Accepts one feature map per `start` from an upstream valid/ready stream and forwards pixels to the line buffer as a registered `lb_din`/`lb_in_valid` pair.
- Tracks row/col position and frame completion.
- Emits a window-valid tag with window indices, aligned to the line-buffer outputs, for a KERNEL x KERNEL window at STRIDE.

Parameters:
- MAP_WIDTH, 24, feature-map columns (>= KERNEL).
- MAP_HEIGHT, 24, feature-map rows (>= KERNEL).
- DATA_WIDTH, 16, pixel width.
- KERNEL, 2, window size (rows held by the line buffer).
- STRIDE, 2, window step in both dimensions (>= 1).
- LB_LATENCY, 1, cycles from `lb_in_valid` to line-buffer output.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begin a frame (ignored unless IDLE).
- m_ready  in  1  downstream can accept window results; low stalls input acceptance.
- s_data  in  DATA_WIDTH  upstream pixel.
- s_valid  in  1  upstream pixel valid.
- s_ready  out  1  controller accepts pixel this cycle.
- lb_clr  out  1  one-cycle clear pulse to line buffer/downstream counters at frame start.
- lb_din  out  DATA_WIDTH  pixel to line buffer.
- lb_in_valid  out  1  `lb_din` valid.
- win_valid  out  1  line-buffer outputs this cycle complete a window.
- win_row  out  $clog2(MAP_HEIGHT)  window row index.
- win_col  out  $clog2(MAP_WIDTH)  window column index.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE; row, col and the delay pipe cleared; all outputs 0 (`lb_din` = 0). Reset mid-frame aborts with no `done` pulse.
- States: IDLE, STREAM, DRAIN.
- IDLE: `s_ready` = 0. On `start` = 1: go to STREAM, `lb_clr` = 1 for exactly that next cycle, row = col = 0.
- STREAM: `s_ready` = `m_ready` (combinational, from state and `m_ready` only; never from `s_valid`).
  - Accept when `s_valid` && `s_ready`: next cycle `lb_din` = `s_data`, `lb_in_valid` = 1; otherwise `lb_in_valid` = 0 and `lb_din` holds.
  - On accept, col increments; at col = MAP_WIDTH-1 it wraps to 0 and row increments.
  - Accept at (MAP_HEIGHT-1, MAP_WIDTH-1) -> DRAIN.
- DRAIN: `s_ready` = 0. Counts LB_LATENCY+1 cycles, then `done` = 1 for one cycle and returns to IDLE.
  - Net effect: `done` occurs in the cycle after the last `win_valid` could occur.
- Window tag: an accepted pixel (r,c) completes a window iff r >= KERNEL-1, c >= KERNEL-1, (r-KERNEL+1) % STRIDE == 0 and (c-KERNEL+1) % STRIDE == 0.
  - Tag index = ((r-KERNEL+1)/STRIDE, (c-KERNEL+1)/STRIDE).
  - The tag travels a shift pipe clocked every cycle (not gated by accept).
  - `win_valid`, `win_row` and `win_col` assert exactly LB_LATENCY+1 cycles after the accepting edge, i.e. LB_LATENCY cycles after the matching `lb_in_valid`.
  - `win_row`/`win_col` are 0 when `win_valid` = 0.
- Arithmetic: modulo/divide for STRIDE a power of two uses a bit slice. For generic STRIDE, keep per-dimension phase counters (0..STRIDE-1) plus window-index counters; no dividers.
- Boundaries:
  - `start` while busy is ignored.
  - `start` coincident with rst: rst wins.
  - `m_ready` drop only withholds `s_ready`; pixels already in the delay pipe still emerge.
  - `s_valid` gaps produce `lb_in_valid` gaps; counters hold.
  - Incomplete trailing windows (width/height not aligned to stride) are never tagged.
- Throughput: 1 pixel/cycle; frame of W*H pixels with no stalls takes W*H + LB_LATENCY + 2 cycles from `start` to `done`.

Decomposition:
- Shared package `cnn_pkg`:
  - state enum (IDLE/STREAM/DRAIN);
  - localparam helpers for counter widths;
  - default MAP_WIDTH/HEIGHT/DATA_WIDTH constants.
- One sub-module: `valid_delay_pipe` (parameterized depth and width; shift register carrying {valid,row,col}), reset to zero.

Test Plan (W=H=4, K=S=2, LB_LATENCY=1 unless stated):
- Reset then `start`, 16 back-to-back pixels 1..16 -> `lb_clr` one cycle; `lb_in_valid` 16 consecutive cycles with `lb_din` 1..16; `win_valid` pulses four times, one each for pixels 6, 8, 14 and 16, with (`win_row`,`win_col`) = (0,0), (0,1), (1,0), (1,1); each pulse 2 cycles after its accept; `done` 19 cycles after `start`.
- `s_valid` toggling 1/0 every cycle -> 16 accepts over 31 cycles, `win_valid` tags identical to scenario 1, no extra `lb_in_valid`.
- `m_ready` held low for 5 cycles after pixel 7 -> `s_ready` = 0 for those 5 cycles; the pending pixel-6 tag still fires on schedule; remaining tags unchanged.
- `start` pulsed again mid-frame and during DRAIN -> ignored; exactly one `done` per frame.
- rst asserted after pixel 9 -> next cycle all outputs 0, state IDLE, no `done`; a fresh `start` yields a correct full frame from (0,0).
- K=3, S=1, W=H=5 -> 9 `win_valid` pulses at pixels (2..4,2..4), indices (0..2,0..2) row-major.
